// File: rtl/matmul_sequencer.sv
// Byte-serial front-end for the 4x4 matrix multiply unit: loads A/B over an 8-bit
// stream, runs the unit for a fixed capture window, then streams the 64-bit result out.
module matmul_sequencer #(
  parameter int unsigned CAPTURE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        mmu_rst_n,
  output logic [63:0] mmu_a,
  output logic [63:0] mmu_b,
  input  logic [63:0] mmu_result
);

  // state  | meaning
  // IDLE   | post-reset, moves to LOAD on the next edge
  // LOAD   | accept 16 operand bytes (A then B, MSB first)
  // RUN    | unit out of reset for CAPTURE_CYCLES edges
  // UNLOAD | emit 8 result bytes, MSB first
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_UNLOAD} state_t;

  localparam logic [3:0] CAP_LAST = 4'(CAPTURE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]  run_cnt_q, run_cnt_d;
  logic [2:0]  out_cnt_q, out_cnt_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [63:0] shift_q, shift_d;
  logic        mmu_rst_n_q, mmu_rst_n_d;
  logic        done_q, done_d;
  logic [5:0]  byte_sel;

  // Byte k of a word lives at bits [63-8k -: 8], so the low index is 8*(7-k).
  assign byte_sel = {~byte_cnt_q[2:0], 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      run_cnt_q   <= '0;
      out_cnt_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      shift_q     <= '0;
      mmu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      run_cnt_q   <= run_cnt_d;
      out_cnt_q   <= out_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      shift_q     <= shift_d;
      mmu_rst_n_q <= mmu_rst_n_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    run_cnt_d   = run_cnt_q;
    out_cnt_d   = out_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    mmu_rst_n_d = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_LOAD;

      S_LOAD: begin
        if (in_valid) begin
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (!byte_cnt_q[3]) a_d[byte_sel +: 8] = in_data;
          else                b_d[byte_sel +: 8] = in_data;
          if (byte_cnt_q == 4'd15) begin
            state_d   = S_RUN;
            run_cnt_d = '0;
          end
        end
      end

      S_RUN: begin
        run_cnt_d = run_cnt_q + 4'd1;
        if (run_cnt_q == CAP_LAST) begin
          shift_d   = mmu_result;
          run_cnt_d = '0;
          out_cnt_d = '0;
          state_d   = S_UNLOAD;
        end
      end

      S_UNLOAD: begin
        if (out_ready) begin
          shift_d   = {shift_q[55:0], 8'h00};
          out_cnt_d = out_cnt_q + 3'd1;
          if (out_cnt_q == 3'd7) begin
            state_d = S_LOAD;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Registered so the unit sees reset released exactly for the RUN window.
    mmu_rst_n_d = (state_d == S_RUN);
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_UNLOAD);
  assign out_data  = shift_q[63:56];
  assign busy      = (state_q == S_RUN) || (state_q == S_UNLOAD);
  assign done      = done_q;
  assign mmu_rst_n = mmu_rst_n_q;
  assign mmu_a     = a_q;
  assign mmu_b     = b_q;

endmodule
